// File: rtl/eth_rx_ring_pkg.sv
// eth_rx_pkg: shared constants and types for the eth_rx_ring receive buffer.
// Optional statistics block is enabled by defining ETH_RX_STATS_EN.
package eth_rx_pkg;

    // CPU register word indices (core_lsu_addr[6:3] inside register space)
    localparam logic [3:0] REG_MAC_LO  = 4'd0;
    localparam logic [3:0] REG_CTRL    = 4'd1;
    localparam logic [3:0] REG_STATUS  = 4'd2;
    localparam logic [3:0] REG_RELEASE = 4'd3;
    localparam logic [3:0] REG_LEN     = 4'd4;
    localparam logic [3:0] REG_STATS   = 4'd5;

    // Station address after reset; first byte on the wire is bits 47:40
    localparam logic [47:0] MAC_RESET    = 48'h230100890702;
    localparam logic [47:0] MAC_BCAST    = 48'hFFFFFFFFFFFF;
    localparam logic [23:0] MCAST_PREFIX = 24'h01005E;

    typedef enum logic [1:0] {IDLE, HDR, ACCEPT, DISCARD} rx_state_e;

    typedef enum logic [2:0] {
        DROP_NONE,
        DROP_OVERFLOW,
        DROP_FILTER,
        DROP_OVERSIZE,
        DROP_FCS,
        DROP_RUNT
    } drop_cause_e;

    // Observation of the receive FSM for checkers
    typedef struct packed {
        rx_state_e   state;
        drop_cause_e cause;
    } rx_dbg_t;

    // Destination filter: own address, broadcast, IPv4 multicast, or promiscuous
    function automatic logic dest_match(input logic [47:0] dest,
                                        input logic [47:0] mac,
                                        input logic        promisc);
        return (dest == mac) || (dest == MAC_BCAST) ||
               (dest[47:24] == MCAST_PREFIX) || promisc;
    endfunction

endpackage

// File: rtl/eth_rx_ring_if.sv
// eth_rx_ring_if: MAC receive byte stream plus the core LSU register/memory port.
// Handshake: the receive stream has no ready; every cycle with rx_tvalid high
// delivers one byte that must be consumed that cycle. rx_tuser is meaningful
// only together with rx_tlast. The LSU side is a strobe bus: ce_d & framing_sel
// selects an access, we_d marks it a write, read data returns one cycle later.
interface eth_rx_ring_if #(parameter int LSU_AW = 15);
    logic [7:0]        rx_tdata;
    logic              rx_tvalid;
    logic              rx_tlast;
    logic              rx_tuser;
    logic [LSU_AW-1:0] core_lsu_addr;
    logic [63:0]       core_lsu_wdata;
    logic [7:0]        core_lsu_be;
    logic              ce_d;
    logic              we_d;
    logic              framing_sel;
    logic [63:0]       framing_rdata;

    modport master (
        output rx_tdata, rx_tvalid, rx_tlast, rx_tuser,
        output core_lsu_addr, core_lsu_wdata, core_lsu_be, ce_d, we_d, framing_sel,
        input  framing_rdata
    );

    modport slave (
        input  rx_tdata, rx_tvalid, rx_tlast, rx_tuser,
        input  core_lsu_addr, core_lsu_wdata, core_lsu_be, ce_d, we_d, framing_sel,
        output framing_rdata
    );
endinterface

// File: rtl/eth_rx_ring_bytemem.sv
// eth_rx_bytemem: packet RAM with byte-granular writes and 64-bit registered
// reads, organised as eight independent byte lanes.
module eth_rx_bytemem #(
    parameter int DEPTH = 2048,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [2:0]    wlane_i,
    input  logic [7:0]    wbyte_i,
    input  logic [AW-1:0] raddr_i,
    output logic [63:0]   rdata_o
);

    for (genvar l = 0; l < 8; l++) begin : g_lane
        logic [7:0] mem [DEPTH];
        logic [7:0] rd_q;

        // One lane: write when this lane is addressed, read every cycle
        always_ff @(posedge clk) begin
            if (we_i && (wlane_i == 3'(l))) begin
                mem[waddr_i] <= wbyte_i;
            end
            rd_q <= mem[raddr_i];
        end

        assign rdata_o[l*8 +: 8] = rd_q;
    end

endmodule

// File: rtl/eth_rx_ring.sv
// eth_rx_ring: receive frame ring. Filters on destination address, discards
// bad/oversize/overflow frames, stores accepted frames in NBUF slots of
// BUF_BYTES each and exposes lengths, pointers and packet data to the core.
// Optional 16-bit drop/accept counters are enabled by ETH_RX_STATS_EN.
module eth_rx_ring
    import eth_rx_pkg::*;
#(
    parameter int NBUF      = 8,
    parameter int BUF_BYTES = 2048,
    parameter int LSU_AW    = 15
) (
    input  logic                msoc_clk,
    input  logic                rstn,
    eth_rx_ring_if.slave        bus,
    output logic                eth_irq,
    output rx_dbg_t             dbg_o
);

    localparam int SLOT_W    = $clog2(NBUF);
    localparam int PTR_W     = SLOT_W + 1;
    localparam int OFF_W     = $clog2(BUF_BYTES);
    localparam int LEN_W     = OFF_W + 1;
    localparam int MEM_WORDS = NBUF * BUF_BYTES / 8;
    localparam int MW        = $clog2(MEM_WORDS);

    // Ring and CPU-visible state
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [47:0]      mac_q;
    logic             irq_en_q, promisc_q, eth_irq_q;
    logic [LEN_W-1:0] len_q [NBUF];
    logic [63:0]      rdata_q;
    logic             ram_sel_q;

    // Receive FSM state
    rx_state_e        state_q, state_d;
    drop_cause_e      cause_q, cause_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [47:0]      dest_q, dest_d;
    logic             mem_we, commit, drop_evt;
    logic [LEN_W-1:0] byte_idx;
    logic [47:0]      hdr_next;

    logic             full, avail;
    logic [SLOT_W-1:0] wr_slot, rd_slot;

    assign wr_slot = wr_ptr_q[SLOT_W-1:0];
    assign rd_slot = rd_ptr_q[SLOT_W-1:0];
    assign full    = (wr_ptr_q - rd_ptr_q) == PTR_W'(NBUF);
    assign avail   = wr_ptr_q != rd_ptr_q;

    // CPU access decode
    logic       acc, reg_space, reg_wr, reg_rd, ram_rd, release_req;
    logic [3:0] reg_idx;

    assign acc         = bus.ce_d & bus.framing_sel;
    assign reg_space   = bus.core_lsu_addr[LSU_AW-1:11] == (LSU_AW-11)'(1);
    assign reg_idx     = bus.core_lsu_addr[6:3];
    assign reg_wr      = acc & bus.we_d & reg_space;
    assign reg_rd      = acc & ~bus.we_d & reg_space;
    assign ram_rd      = acc & ~bus.we_d & bus.core_lsu_addr[LSU_AW-1];
    assign release_req = reg_wr && (reg_idx == REG_RELEASE) && avail;

    // Byte k of the frame: the first byte arrives while still in IDLE
    assign byte_idx = (state_q == IDLE) ? '0 : cnt_q;
    assign hdr_next = {dest_q[39:0], bus.rx_tdata};

    // Receive FSM next-state, byte write and commit/drop decisions
    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        cnt_d    = cnt_q;
        dest_d   = dest_q;
        mem_we   = 1'b0;
        commit   = 1'b0;
        drop_evt = 1'b0;
        if (bus.rx_tvalid) begin
            case (state_q)
                IDLE: begin
                    cnt_d  = LEN_W'(1);
                    dest_d = hdr_next;
                    if (full) begin
                        drop_evt = 1'b1;
                        cause_d  = DROP_OVERFLOW;
                        state_d  = bus.rx_tlast ? IDLE : DISCARD;
                    end else begin
                        mem_we  = 1'b1;
                        cause_d = bus.rx_tlast ? DROP_RUNT : DROP_NONE;
                        state_d = bus.rx_tlast ? IDLE : HDR;
                    end
                end
                HDR: begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + LEN_W'(1);
                    dest_d = hdr_next;
                    if (bus.rx_tlast) begin
                        cause_d = DROP_RUNT;
                        state_d = IDLE;
                    end else if (cnt_q == LEN_W'(5)) begin
                        if (dest_match(hdr_next, mac_q, promisc_q)) begin
                            state_d = ACCEPT;
                        end else begin
                            drop_evt = 1'b1;
                            cause_d  = DROP_FILTER;
                            state_d  = DISCARD;
                        end
                    end
                end
                ACCEPT: begin
                    if (cnt_q[LEN_W-1]) begin
                        // Byte index reached BUF_BYTES: slot would overrun
                        drop_evt = 1'b1;
                        cause_d  = DROP_OVERSIZE;
                        state_d  = bus.rx_tlast ? IDLE : DISCARD;
                    end else begin
                        mem_we = 1'b1;
                        cnt_d  = cnt_q + LEN_W'(1);
                        if (bus.rx_tlast) begin
                            state_d = IDLE;
                            if (bus.rx_tuser) begin
                                drop_evt = 1'b1;
                                cause_d  = DROP_FCS;
                            end else begin
                                commit = 1'b1;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (bus.rx_tlast) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Receive FSM registers
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            cause_q <= DROP_NONE;
            cnt_q   <= '0;
            dest_q  <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            cnt_q   <= cnt_d;
            dest_q  <= dest_d;
        end
    end

    // Pointers, control registers and the interrupt flop
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            mac_q     <= MAC_RESET;
            irq_en_q  <= 1'b0;
            promisc_q <= 1'b0;
            eth_irq_q <= 1'b0;
        end else begin
            if (commit) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (release_req) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            eth_irq_q <= avail & irq_en_q;
            if (reg_wr && (reg_idx == REG_MAC_LO)) begin
                mac_q[31:0] <= bus.core_lsu_wdata[31:0];
            end
            if (reg_wr && (reg_idx == REG_CTRL)) begin
                irq_en_q     <= bus.core_lsu_wdata[63];
                promisc_q    <= bus.core_lsu_wdata[62];
                mac_q[47:32] <= bus.core_lsu_wdata[15:0];
            end
        end
    end

    // Per-slot frame length captured on commit
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NBUF; i++) begin
                len_q[i] <= '0;
            end
        end else if (commit) begin
            len_q[wr_slot] <= byte_idx + LEN_W'(1);
        end
    end

    // Packet storage
    logic [63:0] ram_word;

    eth_rx_bytemem #(.DEPTH(MEM_WORDS), .AW(MW)) u_mem (
        .clk     (msoc_clk),
        .we_i    (mem_we),
        .waddr_i ({wr_slot, byte_idx[OFF_W-1:3]}),
        .wlane_i (byte_idx[2:0]),
        .wbyte_i (bus.rx_tdata),
        .raddr_i (bus.core_lsu_addr[MW+2:3]),
        .rdata_o (ram_word)
    );

    // Statistics counters
    logic [63:0] stats_word;
`ifdef ETH_RX_STATS_EN
    logic [15:0] st_ok_q, st_filt_q, st_ovf_q;
    logic        stats_clr, filt_evt, ovf_evt;

    assign stats_clr = reg_wr && (reg_idx == REG_STATS);
    assign filt_evt  = drop_evt && ((cause_d == DROP_FILTER) || (cause_d == DROP_FCS));
    assign ovf_evt   = drop_evt && ((cause_d == DROP_OVERFLOW) || (cause_d == DROP_OVERSIZE));

    // Saturating event counters; a clear beats a same-cycle increment
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            st_ok_q   <= '0;
            st_filt_q <= '0;
            st_ovf_q  <= '0;
        end else if (stats_clr) begin
            st_ok_q   <= '0;
            st_filt_q <= '0;
            st_ovf_q  <= '0;
        end else begin
            if (commit && (st_ok_q != 16'hFFFF)) st_ok_q <= st_ok_q + 16'd1;
            if (filt_evt && (st_filt_q != 16'hFFFF)) st_filt_q <= st_filt_q + 16'd1;
            if (ovf_evt && (st_ovf_q != 16'hFFFF)) st_ovf_q <= st_ovf_q + 16'd1;
        end
    end

    assign stats_word = {16'd0, st_ovf_q, st_filt_q, st_ok_q};
`else
    assign stats_word = '0;
`endif

    // Register read mux
    logic [63:0] rd_word;
    always_comb begin
        rd_word = '0;
        case (reg_idx)
            REG_MAC_LO: rd_word[31:0] = mac_q[31:0];
            REG_CTRL: begin
                rd_word[63]   = irq_en_q;
                rd_word[62]   = promisc_q;
                rd_word[15:0] = mac_q[47:32];
            end
            REG_STATUS: begin
                rd_word[63]    = eth_irq_q;
                rd_word[62]    = avail;
                rd_word[61]    = full;
                rd_word[23:16] = 8'(wr_ptr_q);
                rd_word[7:0]   = 8'(rd_ptr_q);
            end
            REG_LEN:   rd_word[LEN_W-1:0] = len_q[rd_slot];
            REG_STATS: rd_word = stats_word;
            default:   rd_word = '0;
        endcase
    end

    // Registered read path; zero whenever no register read is selected
    always_ff @(posedge msoc_clk or negedge rstn) begin
        if (!rstn) begin
            rdata_q   <= '0;
            ram_sel_q <= 1'b0;
        end else begin
            rdata_q   <= reg_rd ? rd_word : '0;
            ram_sel_q <= ram_rd;
        end
    end

    assign bus.framing_rdata = ram_sel_q ? ram_word : rdata_q;
    assign eth_irq           = eth_irq_q;
    assign dbg_o             = '{state: state_q, cause: cause_q};

    // Byte enables and unused address/data bits carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{bus.core_lsu_be, bus.core_lsu_wdata, bus.core_lsu_addr, drop_evt};

endmodule

// File: tb/tb_eth_rx_ring.sv
// tb_eth_rx_ring: directed self-checking bench for eth_rx_ring (default
// parameters NBUF=8, BUF_BYTES=2048, LSU_AW=15). ETH_RX_STATS_EN selects the
// expected statistics readback.
module tb_eth_rx_ring;
  import eth_rx_pkg::*;

  localparam logic [47:0] MAC_ME = 48'h230100890702;
  localparam logic [47:0] BCAST  = 48'hFFFFFFFFFFFF;
  localparam logic [47:0] MCAST  = 48'h01005E000001;
  localparam logic [47:0] OTHER  = 48'h020000000001;

  logic    clk = 1'b0;
  logic    rstn = 1'b0;
  logic    eth_irq;
  rx_dbg_t dbg;
  int      checks = 0;
  int      errors = 0;
  int      wp = 0;
  int      rp = 0;

  eth_rx_ring_if #(.LSU_AW(15)) bus();

  eth_rx_ring dut (
    .msoc_clk (clk),
    .rstn     (rstn),
    .bus      (bus),
    .eth_irq  (eth_irq),
    .dbg_o    (dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // frame byte i: destination first, then a seed-dependent payload
  function automatic logic [7:0] byte_at(input logic [47:0] dst, input int seed, input int i);
    if (i < 6) return dst[47-8*i -: 8];
    return 8'((seed * 7 + i) & 255);
  endfunction

  function automatic logic [63:0] ram_exp(input logic [47:0] dst, input int seed, input int base);
    logic [63:0] w;
    for (int j = 0; j < 8; j++) w[8*j +: 8] = byte_at(dst, seed, base + j);
    return w;
  endfunction

  function automatic logic [63:0] status_exp(input logic irq);
    logic [63:0] s;
    int          n;
    s = '0;
    n = (wp - rp) & 15;
    s[63] = irq;
    s[62] = (n != 0);
    s[61] = (n == 8);
    s[23:16] = 8'(wp);
    s[7:0] = 8'(rp);
    return s;
  endfunction

  // driver tasks
  task automatic bus_idle();
    bus.rx_tvalid = 1'b0; bus.rx_tdata = '0; bus.rx_tlast = 1'b0; bus.rx_tuser = 1'b0;
    bus.core_lsu_addr = '0; bus.core_lsu_wdata = '0; bus.core_lsu_be = '0;
    bus.ce_d = 1'b0; bus.we_d = 1'b0; bus.framing_sel = 1'b0;
  endtask

  task automatic send_frame(input logic [47:0] dst, input int len, input int seed, input logic tuser);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.rx_tvalid = 1'b1;
      bus.rx_tdata = byte_at(dst, seed, i);
      bus.rx_tlast = (i == len - 1);
      bus.rx_tuser = (i == len - 1) ? tuser : 1'b0;
    end
    @(negedge clk);
    bus.rx_tvalid = 1'b0; bus.rx_tlast = 1'b0; bus.rx_tuser = 1'b0;
  endtask

  task automatic cpu_write(input logic [3:0] idx, input logic [63:0] d);
    @(negedge clk);
    bus.core_lsu_addr = 15'h0800 | (15'(idx) << 3);
    bus.core_lsu_wdata = d; bus.core_lsu_be = 8'hFF;
    bus.ce_d = 1'b1; bus.we_d = 1'b1; bus.framing_sel = 1'b1;
    @(negedge clk);
    bus.ce_d = 1'b0; bus.we_d = 1'b0; bus.framing_sel = 1'b0;
  endtask

  task automatic cpu_read(input logic [14:0] addr, output logic [63:0] d);
    @(negedge clk);
    bus.core_lsu_addr = addr;
    bus.ce_d = 1'b1; bus.we_d = 1'b0; bus.framing_sel = 1'b1;
    @(negedge clk);
    d = bus.framing_rdata;
    bus.ce_d = 1'b0; bus.framing_sel = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] idx, output logic [63:0] d);
    cpu_read(15'h0800 | (15'(idx) << 3), d);
  endtask

  task automatic release_one();
    cpu_write(REG_RELEASE, '0);
    if (wp != rp) rp = (rp + 1) % 16;
  endtask

  // scenarios
  task automatic test_reset();
    logic [63:0] d;
    bus_idle();
    #23;
    checks++; if (bus.framing_rdata !== 64'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", bus.framing_rdata); end
    checks++; if (eth_irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", eth_irq); end
    @(negedge clk); rstn = 1'b1;
    checks++; if (dbg.state !== IDLE) begin errors++; $display("FAIL reset_state got %0d exp IDLE", dbg.state); end
    reg_read(REG_MAC_LO, d);
    checks++; if (d !== 64'h0000_0000_0089_0702) begin errors++; $display("FAIL reset_mac_lo got %h exp %h", d, 64'h0089_0702); end
    reg_read(REG_CTRL, d);
    checks++; if (d !== 64'h0000_0000_0000_2301) begin errors++; $display("FAIL reset_ctrl got %h exp %h", d, 64'h2301); end
    reg_read(REG_STATUS, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL reset_status got %h exp 0", d); end
  endtask

  task automatic test_unicast();
    logic [63:0] d;
    send_frame(MAC_ME, 64, 1, 1'b0);
    wp = 1;
    reg_read(REG_STATUS, d);
    checks++; if (d !== 64'h4000_0000_0001_0000) begin errors++; $display("FAIL uni_status got %h exp %h", d, 64'h4000_0000_0001_0000); end
    reg_read(REG_LEN, d);
    checks++; if (d !== 64'd64) begin errors++; $display("FAIL uni_len got %0d exp 64", d); end
    cpu_read(15'h4000, d);
    checks++; if (d !== ram_exp(MAC_ME, 1, 0)) begin errors++; $display("FAIL uni_word0 got %h exp %h", d, ram_exp(MAC_ME, 1, 0)); end
    cpu_read(15'h4000 | 15'd56, d);
    checks++; if (d !== ram_exp(MAC_ME, 1, 56)) begin errors++; $display("FAIL uni_word7 got %h exp %h", d, ram_exp(MAC_ME, 1, 56)); end
    release_one();
    reg_read(REG_STATUS, d);
    checks++; if (d !== 64'h0000_0000_0001_0001) begin errors++; $display("FAIL uni_release got %h exp %h", d, 64'h0001_0001); end
  endtask

  task automatic test_filter();
    logic [47:0] dsts [3];
    logic        acc [3];
    logic [63:0] d;
    dsts = '{BCAST, MCAST, OTHER};
    acc = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      send_frame(dsts[i], 60, 2 + i, 1'b0);
      if (acc[i]) wp = (wp + 1) % 16;
      reg_read(REG_STATUS, d);
      checks++; if (d !== status_exp(1'b0)) begin errors++; $display("FAIL filter_%0d got %h exp %h", i, d, status_exp(1'b0)); end
    end
    cpu_write(REG_CTRL, 64'h4000_0000_0000_2301);
    reg_read(REG_CTRL, d);
    checks++; if (d !== 64'h4000_0000_0000_2301) begin errors++; $display("FAIL promisc_ctrl got %h exp %h", d, 64'h4000_0000_0000_2301); end
    send_frame(OTHER, 60, 5, 1'b0);
    wp = (wp + 1) % 16;
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b0)) begin errors++; $display("FAIL promisc_accept got %h exp %h", d, status_exp(1'b0)); end
    cpu_write(REG_CTRL, 64'h0000_0000_0000_2301);
    while (rp != wp) release_one();
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b0)) begin errors++; $display("FAIL filter_drain got %h exp %h", d, status_exp(1'b0)); end
  endtask

  task automatic test_bad_frames();
    logic [63:0] d;
    int          base;
    send_frame(MAC_ME, 64, 6, 1'b1);
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b0)) begin errors++; $display("FAIL bad_fcs got %h exp %h", d, status_exp(1'b0)); end
    send_frame(MAC_ME, 4, 7, 1'b0);
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b0)) begin errors++; $display("FAIL runt got %h exp %h", d, status_exp(1'b0)); end
    send_frame(MAC_ME, 2049, 8, 1'b0);
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b0)) begin errors++; $display("FAIL oversize got %h exp %h", d, status_exp(1'b0)); end
    base = (wp % 8) * 2048;
    send_frame(MAC_ME, 100, 9, 1'b0);
    wp = (wp + 1) % 16;
    reg_read(REG_LEN, d);
    checks++; if (d !== 64'd100) begin errors++; $display("FAIL reuse_len got %0d exp 100", d); end
    cpu_read(15'h4000 | 15'(base + 8), d);
    checks++; if (d !== ram_exp(MAC_ME, 9, 8)) begin errors++; $display("FAIL reuse_word got %h exp %h", d, ram_exp(MAC_ME, 9, 8)); end
    release_one();
  endtask

  task automatic test_overflow();
    logic [63:0] d;
    logic [63:0] st_exp;
    cpu_write(REG_STATS, '0);
    for (int i = 0; i < 9; i++) begin
      send_frame(MAC_ME, 64, 20 + i, 1'b0);
      if (i < 8) wp = (wp + 1) % 16;
    end
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b0) || d[61] !== 1'b1) begin errors++; $display("FAIL full_status got %h exp %h", d, status_exp(1'b0)); end
`ifdef ETH_RX_STATS_EN
    st_exp = 64'h0000_0001_0000_0008;
`else
    st_exp = 64'h0;
`endif
    reg_read(REG_STATS, d);
    checks++; if (d !== st_exp) begin errors++; $display("FAIL stats got %h exp %h", d, st_exp); end
    release_one();
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b0) || d[61] !== 1'b0) begin errors++; $display("FAIL unfull_status got %h exp %h", d, status_exp(1'b0)); end
    cpu_read(15'h4000 | 15'((rp % 8) * 2048 + 8), d);
    checks++; if (d !== ram_exp(MAC_ME, 21, 8)) begin errors++; $display("FAIL ovf_word got %h exp %h", d, ram_exp(MAC_ME, 21, 8)); end
    while (rp != wp) release_one();
  endtask

  task automatic test_wrap();
    logic [63:0] d;
    int          len;
    int          base;
    for (int i = 0; i < 20; i++) begin
      len = 20 + 3 * i;
      base = (wp % 8) * 2048;
      send_frame(MAC_ME, len, 40 + i, 1'b0);
      wp = (wp + 1) % 16;
      reg_read(REG_LEN, d);
      checks++; if (d !== 64'(len)) begin errors++; $display("FAIL wrap_len_%0d got %0d exp %0d", i, d, len); end
      cpu_read(15'h4000 | 15'(base + 8), d);
      checks++; if (d !== ram_exp(MAC_ME, 40 + i, 8)) begin errors++; $display("FAIL wrap_word_%0d got %h exp %h", i, d, ram_exp(MAC_ME, 40 + i, 8)); end
      release_one();
    end
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b0)) begin errors++; $display("FAIL wrap_status got %h exp %h", d, status_exp(1'b0)); end
  endtask

  task automatic test_irq();
    logic [63:0] d;
    cpu_write(REG_CTRL, 64'h8000_0000_0000_2301);
    send_frame(MAC_ME, 64, 60, 1'b0);
    wp = (wp + 1) % 16;
    @(negedge clk);
    checks++; if (eth_irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b exp 1", eth_irq); end
    reg_read(REG_STATUS, d);
    checks++; if (d !== status_exp(1'b1)) begin errors++; $display("FAIL irq_status got %h exp %h", d, status_exp(1'b1)); end
    release_one();
    checks++; if (eth_irq !== 1'b1) begin errors++; $display("FAIL irq_lag got %b exp 1", eth_irq); end
    @(negedge clk);
    checks++; if (eth_irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b exp 0", eth_irq); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    send_frame(MAC_ME, 64, 70, 1'b0);
    @(negedge clk);
    bus.core_lsu_addr = 15'h0800; bus.ce_d = 1'b1; bus.we_d = 1'b0; bus.framing_sel = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.rx_tvalid = 1'b1; bus.rx_tdata = byte_at(MAC_ME, 71, i); bus.rx_tlast = 1'b0;
    end
    checks++; if (eth_irq !== 1'b1 || bus.framing_rdata !== 64'h0089_0702) begin errors++; $display("FAIL pre_reset irq %b rdata %h exp 1 %h", eth_irq, bus.framing_rdata, 64'h0089_0702); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (eth_irq !== 1'b0) begin errors++; $display("FAIL midrst_irq got %b exp 0", eth_irq); end
    checks++; if (bus.framing_rdata !== 64'h0) begin errors++; $display("FAIL midrst_rdata got %h exp 0", bus.framing_rdata); end
    @(negedge clk); bus_idle();
    @(negedge clk); rstn = 1'b1;
    wp = 0; rp = 0;
    reg_read(REG_STATUS, d);
    checks++; if (d !== 64'h0) begin errors++; $display("FAIL midrst_status got %h exp 0", d); end
    reg_read(REG_CTRL, d);
    checks++; if (d !== 64'h0000_0000_0000_2301) begin errors++; $display("FAIL midrst_ctrl got %h exp %h", d, 64'h2301); end
  endtask

  // sequence and final report
  initial begin
    test_reset();
    test_unicast();
    test_filter();
    test_bad_frames();
    test_overflow();
    test_wrap();
    test_irq();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eth_rx_ring.md
Name: eth_rx_ring

Overview:
- Parametrised receive-side packet buffer ring for the Ethernet framing path. It replaces the fixed 8-slot, 11-bit-length receive bookkeeping of the current framing block.
- Sits between the MAC receive AXI-stream (output of the receive MAC core, already in the msoc_clk domain) and the core LSU register/memory port.
- Performs destination-address filtering, bad-frame/oversize/overflow discard and per-slot length capture into an NBUF-deep ring. Raises eth_irq while frames are pending.

Parameters:
- NBUF, 8, number of ring slots; power of 2, range 2..64.
- BUF_BYTES, 2048, bytes per slot; power of 2, range 64..4096.
- LSU_AW, 15, core_lsu_addr width; must satisfy 2^(LSU_AW-1) >= NBUF*BUF_BYTES.

Ports:
- msoc_clk  in  1  sole clock.
- rstn  in  1  asynchronous active-low reset.
- rx_tdata  in  8  received byte.
- rx_tvalid  in  1  byte valid; there is no backpressure.
- rx_tlast  in  1  last byte of frame.
- rx_tuser  in  1  bad frame/FCS; sampled only with rx_tlast.
- core_lsu_addr  in  LSU_AW  byte address.
- core_lsu_wdata  in  64  write data.
- core_lsu_be  in  8  byte enables.
- ce_d  in  1  access strobe.
- we_d  in  1  write qualifier.
- framing_sel  in  1  block select.
- framing_rdata  out  64  read data.
- eth_irq  out  1  frame-pending interrupt.

Behaviour:
- Reset (async, rstn low):
  - framing_rdata = 0, eth_irq = 0.
  - wr_ptr = rd_ptr = 0; pointers are log2(NBUF)+1 bits wide.
  - mac_address = 48'h230100890702.
  - irq_en = 0, promiscuous = 0, FSM = IDLE.
  - Reset mid-frame abandons the frame; the ring reads empty.
- Ring state:
  - full = (wr_ptr - rd_ptr) == NBUF.
  - avail = wr_ptr != rd_ptr.
  - Slot index = ptr[log2(NBUF)-1:0]; pointers wrap modulo 2*NBUF.
- FSM states:
  - IDLE: on rx_tvalid, go to HDR if not full, else DISCARD with drop_cause = overflow. Byte count = 0.
  - HDR: shift the first 6 bytes into dest_mac. After byte 6, compute match = (dest == mac_address) | (dest == all-ones) | (dest[47:24] == 24'h01005E) | promiscuous. Go to ACCEPT if match, else DISCARD.
  - ACCEPT: continue writing bytes.
  - DISCARD: accept and ignore bytes until rx_tlast.
- Byte writes (HDR and ACCEPT): byte k of the frame goes to slot wr_slot, word k>>3, lane k[2:0], written the cycle it arrives. A byte with k >= BUF_BYTES forces DISCARD (oversize).
- Frame end: rx_tlast in ACCEPT with rx_tuser == 0 commits the frame:
  - len[wr_slot] <= k+1 (width log2(BUF_BYTES)+1).
  - wr_ptr increments the following cycle.
  - Otherwise the frame is discarded. A frame shorter than 6 bytes is always discarded.
  - Every state returns to IDLE after rx_tlast.
- CPU write decode (ce_d & framing_sel & we_d):
  - Register space is addr[LSU_AW-1:11] == 1; the word index is addr[6:3].
  - 0: mac_address[31:0].
  - 1: {irq_en (bit 63), promiscuous (bit 62), mac_address[47:32] (bits 15:0)}.
  - 3: release; rd_ptr++ if avail, ignored if empty.
  - Writes to all other indices are ignored. Byte enables are ignored for registers.
- CPU read decode: framing_rdata is registered with 1-cycle latency and is 0 when no read is selected.
  - 0/1: readback of the written fields.
  - 2: {eth_irq (bit 63), avail (bit 62), full (bit 61), wr_ptr (bits 23:16), rd_ptr (bits 7:0)}; pointers zero-extended.
  - 4: len of the rd_ptr slot.
  - addr[LSU_AW-1] == 1: packet RAM word at byte offset addr[LSU_AW-2:0].
- Simultaneous commit and release in the same cycle: both pointer updates apply; the count is unchanged.
- eth_irq <= avail & irq_en, registered. Clearing irq_en drops eth_irq on the next cycle.

Optional Feature:
- Macro ETH_RX_STATS_EN.
- When defined:
  - Three 16-bit saturating counters: rx_ok, rx_drop_filter (address mismatch and bad FCS), rx_drop_overflow (full and oversize).
  - Read at register index 5 as {rx_drop_overflow, rx_drop_filter, rx_ok} in bits 47:0.
  - Any write to index 5 clears all three counters; if an increment and the clear happen in the same cycle, the clear wins.
- When undefined: no counters, and index 5 reads 0.

Decomposition:
- Package eth_rx_pkg holds:
  - the register index constants,
  - the FSM state enum {IDLE, HDR, ACCEPT, DISCARD},
  - the drop-cause enum,
  - the reset MAC constant,
  - the broadcast and multicast prefix constants.
- Sub-module eth_rx_bytemem: an NBUF*BUF_BYTES byte-write / 64-bit-read single-clock RAM built as 8 byte lanes, with registered read.

Test Plan:
- mac_address reset value; 64-byte frame to 23:01:00:89:07:02 with tuser = 0 -> status avail = 1, wr_ptr = 1; index 4 reads 64; RAM word 0 matches bytes 0..7.
- Frame to ff:ff:ff:ff:ff:ff -> accepted. Frame to 01:00:5e:00:00:01 -> accepted. Frame to 02:00:00:00:00:01 -> dropped with wr_ptr unchanged; the same frame with promiscuous = 1 -> accepted.
- Matching frame with rx_tuser = 1 on tlast -> dropped. Frame of 2049 bytes -> dropped and the slot is reused by the next frame.
- NBUF = 8: send 9 frames with no release -> the first 8 are committed, full = 1, the 9th is dropped (rx_drop_overflow = 1 when ETH_RX_STATS_EN). Release once -> full = 0.
- Run 20 frames with a release after each -> pointers wrap past 15 to 0; lengths and data stay correct in every slot.
- irq_en = 1 with one pending frame -> eth_irq = 1. Release -> eth_irq = 0 one cycle after avail falls. Assert rstn mid-frame -> all outputs 0 immediately.
